mesh_router_param: RTL and testbench

Parametrised five-port mesh router, the next generation of the fixed 3x3 mesh router. It adds configurable flit width, mesh size, per-input FIFO depth, a selectable XY/YX dimension-order routing mode, round-robin output arbitration and out-of-mesh flit dropping with a sticky error flag. Port order is 0 local, 1 north (Y-1), 2 east (X+1), 3 south (Y+1), 4 west (X-1). Mesh top levels instantiate one per tile and tie edge ports off.

---
 rtl/noc_router_pkg.sv | 42 ++++
 rtl/router_fifo.sv | 54 +++++
 rtl/mesh_router_param.sv | 133 +++++++++++++
 tb/tb_mesh_router_param.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_router_pkg.sv
// Shared definitions for the parametrised mesh router: port numbering,
// routing modes and the dimension-order route function.
package noc_router_pkg;

    localparam int N_PORTS = 5;

    typedef logic [2:0] port_t;

    localparam port_t P_LOCAL = 3'd0;
    localparam port_t P_NORTH = 3'd1;
    localparam port_t P_EAST  = 3'd2;
    localparam port_t P_SOUTH = 3'd3;
    localparam port_t P_WEST  = 3'd4;

    localparam bit MODE_XY = 1'b0;
    localparam bit MODE_YX = 1'b1;

    // Coordinates are zero-extended to a fixed width so one function serves every CW.
    localparam int CW_MAX = 8;
    typedef logic [CW_MAX-1:0] coord_t;

    function automatic port_t route_port(input coord_t dy, input coord_t dx,
                                         input coord_t ry, input coord_t rx,
                                         input bit yx_mode);
        port_t p;
        if (yx_mode == MODE_YX) begin
            if (dy > ry)      p = P_SOUTH;
            else if (dy < ry) p = P_NORTH;
            else if (dx > rx) p = P_EAST;
            else if (dx < rx) p = P_WEST;
            else              p = P_LOCAL;
        end else begin
            if (dx > rx)      p = P_EAST;
            else if (dx < rx) p = P_WEST;
            else if (dy > ry) p = P_SOUTH;
            else if (dy < ry) p = P_NORTH;
            else              p = P_LOCAL;
        end
        return p;
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-input flit FIFO with registered occupancy count and a
// combinational head read.
module router_fifo #(
    parameter int PL    = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [PL-1:0]                wdata,
    input  logic                         pop,
    output logic [PL-1:0]                rdata,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [PL-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CNTW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mesh_router_param.sv
// Five-port mesh router tile: input FIFOs, dimension-order routing,
// round-robin output arbitration and out-of-mesh drop with sticky flag.
module mesh_router_param
    import noc_router_pkg::*;
#(
    parameter int PL      = 32,
    parameter int MESH_X  = 3,
    parameter int MESH_Y  = 3,
    parameter int CW      = 2,
    parameter int DEPTH   = 4,
    parameter bit YX_MODE = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CW-1:0]                router_Y,
    input  logic [CW-1:0]                router_X,
    input  logic [N_PORTS-1:0][PL-1:0]   in_data,
    input  logic [N_PORTS-1:0]           in_valid,
    output logic [N_PORTS-1:0]           in_ready,
    output logic [N_PORTS-1:0][PL-1:0]   out_data,
    output logic [N_PORTS-1:0]           out_valid,
    input  logic [N_PORTS-1:0]           out_ready,
    output logic                         err_drop
);

    localparam int CNTW = $clog2(DEPTH) + 1;

    logic [N_PORTS-1:0][PL-1:0]   head;
    logic [N_PORTS-1:0][CNTW-1:0] count;
    logic [N_PORTS-1:0]           fifo_full;
    logic [N_PORTS-1:0]           empty;
    logic [N_PORTS-1:0]           push;
    logic [N_PORTS-1:0]           pop;
    logic [N_PORTS-1:0]           drop;
    logic [N_PORTS-1:0]           slot_free;
    logic [N_PORTS-1:0][N_PORTS-1:0] req;      // req[output][input]
    logic [N_PORTS-1:0]           win_valid;
    port_t [N_PORTS-1:0]          win_idx;
    port_t [N_PORTS-1:0]          rr_ptr;
    logic [CW-1:0]                dy;
    logic [CW-1:0]                dx;
    logic [3:0]                   pick;

    // Returns {found, index}: first requester at or above ptr, wrapping modulo N_PORTS.
    function automatic logic [3:0] rr_pick(input logic [N_PORTS-1:0] r, input port_t ptr);
        logic [3:0] c;
        logic [3:0] res;
        res = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            c = {1'b0, ptr} + 4'(k);
            if (c >= 4'(N_PORTS)) c = c - 4'(N_PORTS);
            if (r[c[2:0]]) res = {1'b1, c[2:0]};
        end
        return res;
    endfunction

    for (genvar g = 0; g < N_PORTS; g++) begin : g_fifo
        router_fifo #(.PL(PL), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[g]),
            .wdata (in_data[g]),
            .pop   (pop[g]),
            .rdata (head[g]),
            .count (count[g]),
            .full  (fifo_full[g]),
            .empty (empty[g])
        );
        assign in_ready[g] = (count[g] != CNTW'(DEPTH));
        assign push[g]     = in_valid[g] && !fifo_full[g];
    end

    assign slot_free = ~out_valid | out_ready;

    // Destination Y sits in the top CW bits of the flit, X just below it.
    always_comb begin
        req  = '0;
        drop = '0;
        dy   = '0;
        dx   = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            dy = head[i][PL-1 -: CW];
            dx = head[i][PL-1-CW -: CW];
            if (!empty[i]) begin
                if (int'(dy) >= MESH_Y || int'(dx) >= MESH_X)
                    drop[i] = 1'b1;
                else
                    req[route_port(coord_t'(dy), coord_t'(dx), coord_t'(router_Y),
                                   coord_t'(router_X), YX_MODE)][i] = 1'b1;
            end
        end
    end

    // A head has exactly one route, so at most one output can claim each input.
    always_comb begin
        pop       = drop;
        win_valid = '0;
        win_idx   = '0;
        pick      = '0;
        for (int o = 0; o < N_PORTS; o++) begin
            pick = rr_pick(req[o], rr_ptr[o]);
            if (slot_free[o] && pick[3]) begin
                win_valid[o]     = 1'b1;
                win_idx[o]       = pick[2:0];
                pop[pick[2:0]]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_data  <= '0;
            rr_ptr    <= '0;
            err_drop  <= 1'b0;
        end else begin
            for (int o = 0; o < N_PORTS; o++) begin
                if (slot_free[o]) begin
                    if (win_valid[o]) begin
                        out_valid[o] <= 1'b1;
                        out_data[o]  <= head[win_idx[o]];
                        rr_ptr[o]    <= (win_idx[o] == port_t'(N_PORTS - 1)) ? port_t'(0)
                                                                            : win_idx[o] + port_t'(1);
                    end else begin
                        out_valid[o] <= 1'b0;
                    end
                end
            end
            if (|drop) err_drop <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mesh_router_param.sv
// Scoreboard bench for mesh_router_param at tile (1,1) of a 3x3 mesh,
// with a second YX-mode instance for the routing-mode comparison.
module tb_mesh_router_param;
    import noc_router_pkg::*;

    localparam int PL = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]               ry = 2'd1;
    logic [1:0]               rx = 2'd1;
    logic [PL-1:0]            drv_data  [5];
    logic                     drv_valid [5];
    logic [4:0][PL-1:0]       in_data;
    logic [4:0]               in_valid;
    logic [4:0]               in_ready;
    logic [4:0][PL-1:0]       out_data;
    logic [4:0]               out_valid;
    logic [4:0]               out_ready;
    logic                     err_drop;
    logic [4:0]               in_valid_yx;
    logic [4:0]               in_ready_yx;
    logic [4:0][PL-1:0]       out_data_yx;
    logic [4:0]               out_valid_yx;
    logic                     err_drop_yx;

    logic [PL-1:0] exp_q    [5][$];
    logic [PL-1:0] exp_yx_q [5][$];
    logic [PL-1:0] mon_e;
    logic [PL-1:0] mon_e_yx;
    int checks = 0;
    int errors = 0;

    always_comb begin
        for (int p = 0; p < 5; p++) begin
            in_data[p]  = drv_data[p];
            in_valid[p] = drv_valid[p];
        end
    end

    mesh_router_param #(.PL(PL), .MESH_X(3), .MESH_Y(3), .CW(2), .DEPTH(4), .YX_MODE(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .router_Y(ry), .router_X(rx),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .err_drop(err_drop)
    );

    mesh_router_param #(.PL(PL), .MESH_X(3), .MESH_Y(3), .CW(2), .DEPTH(4), .YX_MODE(1'b1)) dut_yx (
        .clk(clk), .rst_n(rst_n), .router_Y(ry), .router_X(rx),
        .in_data(in_data), .in_valid(in_valid_yx), .in_ready(in_ready_yx),
        .out_data(out_data_yx), .out_valid(out_valid_yx), .out_ready(5'b11111),
        .err_drop(err_drop_yx)
    );

    function automatic logic [PL-1:0] mk(input logic [1:0] fy, input logic [1:0] fx, input logic [27:0] pl);
        return {fy, fx, pl};
    endfunction

    function automatic int pending();
        int n = 0;
        for (int p = 0; p < 5; p++) n += exp_q[p].size() + exp_yx_q[p].size();
        return n;
    endfunction

    task automatic chk(input string name, input logic [PL-1:0] act, input logic [PL-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the flit.
    task automatic send(input int p, input logic [PL-1:0] d);
        int guard = 0;
        drv_data[p]  = d;
        drv_valid[p] = 1'b1;
        @(negedge clk);
        while (!in_ready[p] && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout port %0d: in_ready stayed 0, expected 1", p);
        end
        @(posedge clk);
        #1;
        drv_valid[p] = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (pending() != 0 && guard < 500) begin
            @(posedge clk);
            guard++;
        end
        #1;
        checks++;
        if (pending() != 0) begin
            errors++;
            $display("FAIL drain: %0d flits outstanding, expected 0", pending());
        end
    endtask

    // Monitor: every handshake pops the expected flit for that output.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < 5; p++) begin
                if (out_valid[p] && out_ready[p]) begin
                    checks++;
                    if (exp_q[p].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_out port %0d: got %h, expected none", p, out_data[p]);
                    end else begin
                        mon_e = exp_q[p].pop_front();
                        if (mon_e !== out_data[p]) begin
                            errors++;
                            $display("FAIL out_data port %0d: got %h expected %h", p, out_data[p], mon_e);
                        end
                    end
                end
                if (out_valid_yx[p]) begin
                    checks++;
                    if (exp_yx_q[p].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_out_yx port %0d: got %h, expected none", p, out_data_yx[p]);
                    end else begin
                        mon_e_yx = exp_yx_q[p].pop_front();
                        if (mon_e_yx !== out_data_yx[p]) begin
                            errors++;
                            $display("FAIL out_data_yx port %0d: got %h expected %h", p, out_data_yx[p], mon_e_yx);
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [PL-1:0] f;
        for (int p = 0; p < 5; p++) begin
            drv_data[p]  = '0;
            drv_valid[p] = 1'b0;
        end
        in_valid_yx = '0;
        out_ready   = 5'b11111;

        #2;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1f);
        chk("rst_err_drop", 32'(err_drop), 32'h0);
        chk("rst_out_data2", out_data[2], 32'h0);
        chk("rst_out_valid_yx", 32'(out_valid_yx), 32'h0);
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // Dest (0,2) from local: XY goes east, YX goes north; check t+1 latency.
        f = mk(2'd0, 2'd2, 28'h00000a1);
        exp_q[2].push_back(f);
        exp_yx_q[1].push_back(f);
        drv_data[0]    = f;
        drv_valid[0]   = 1'b1;
        in_valid_yx[0] = 1'b1;
        tick(1);
        drv_valid[0]   = 1'b0;
        in_valid_yx[0] = 1'b0;
        chk("lat_edge_t_valid", 32'(out_valid[2]), 32'h0);
        tick(1);
        chk("lat_edge_t1_valid", 32'(out_valid[2]), 32'h1);
        chk("lat_edge_t1_data", out_data[2], f);
        chk("yx_north_valid", 32'(out_valid_yx[1]), 32'h1);
        wait_drain();

        // Round-robin on local output: fresh pointers, north/east/west all target (1,1).
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        for (int k = 0; k < 3; k++) begin
            exp_q[0].push_back(mk(2'd1, 2'd1, {4'd1, 24'(k)}));
            exp_q[0].push_back(mk(2'd1, 2'd1, {4'd2, 24'(k)}));
            exp_q[0].push_back(mk(2'd1, 2'd1, {4'd4, 24'(k)}));
        end
        fork
            begin
                for (int k = 0; k < 3; k++) send(1, mk(2'd1, 2'd1, {4'd1, 24'(k)}));
            end
            begin
                for (int j = 0; j < 3; j++) send(2, mk(2'd1, 2'd1, {4'd2, 24'(j)}));
            end
            begin
                for (int m = 0; m < 3; m++) send(4, mk(2'd1, 2'd1, {4'd4, 24'(m)}));
            end
        join
        wait_drain();

        // Backpressure: east blocked, 5 flits -> 1 in slot, 4 buffered.
        out_ready[2] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_q[2].push_back(mk(2'd1, 2'd2, 28'h0000b00 + 28'(k)));
            send(0, mk(2'd1, 2'd2, 28'h0000b00 + 28'(k)));
        end
        chk("bp_in_ready0", 32'(in_ready[0]), 32'h0);
        chk("bp_slot_valid", 32'(out_valid[2]), 32'h1);
        chk("bp_slot_data", out_data[2], mk(2'd1, 2'd2, 28'h0000b00));
        tick(3);
        chk("bp_hold_valid", 32'(out_valid[2]), 32'h1);
        chk("bp_hold_data", out_data[2], mk(2'd1, 2'd2, 28'h0000b00));
        chk("bp_hold_in_ready0", 32'(in_ready[0]), 32'h0);
        out_ready[2] = 1'b1;
        wait_drain();

        // Out-of-mesh destination (3,0) is dropped and flagged.
        send(0, mk(2'd3, 2'd0, 28'h0000dd0));
        tick(2);
        chk("drop_err", 32'(err_drop), 32'h1);
        chk("drop_no_out", 32'(out_valid), 32'h0);
        f = mk(2'd2, 2'd1, 28'h0000dd1);
        exp_q[3].push_back(f);
        send(0, f);
        wait_drain();
        chk("drop_err_sticky", 32'(err_drop), 32'h1);

        // Local delivery and a 16-flit stream through one FIFO.
        f = mk(2'd1, 2'd1, 28'h0000e00);
        exp_q[0].push_back(f);
        send(2, f);
        for (int k = 0; k < 16; k++) begin
            exp_q[3].push_back(mk(2'd2, 2'd1, 28'h0000f00 + 28'(k)));
            send(0, mk(2'd2, 2'd1, 28'h0000f00 + 28'(k)));
        end
        wait_drain();

        // Reset mid-traffic: buffered flits must vanish.
        out_ready[2] = 1'b0;
        for (int k = 0; k < 3; k++) send(0, mk(2'd1, 2'd2, 28'h0000c00 + 28'(k)));
        tick(1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_in_ready", 32'(in_ready), 32'h1f);
        chk("midrst_err_drop", 32'(err_drop), 32'h0);
        tick(2);
        rst_n = 1'b1;
        out_ready = 5'b11111;
        tick(20);
        chk("post_rst_idle", 32'(out_valid), 32'h0);
        f = mk(2'd0, 2'd1, 28'h0000c10);
        exp_q[1].push_back(f);
        send(0, f);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
